option_scheduler: RTL and testbench
===================================

# option_scheduler

Sequencing controller for the Monte-Carlo risk datapath. It accepts option parameter sets over a valid/ready handshake and launches the ExpMu and ExpSigma generator banks. It tracks their completion, steers the round-robin lane select for table write-back and flips the double-buffered table bank. It then launches the MC cores so that table generation for option N+1 overlaps core simulation of option N. It replaces the ad-hoc start/busy/ready logic in the top level with two explicit FSMs.

## Interface
- GEN_LANES, 3, number of parallel generator lanes per bank (ExpMu and ExpSigma banks have equal lane count)
- SEL_W, 2, width of lane select; must satisfy 2^SEL_W >= GEN_LANES
- CNT_W, 16, width of completed-option counter

- CLK  in  1  system clock, all state on rising edge
- iRstN  in  1  asynchronous active-low reset
- iOptValid  in  1  option parameters (Mu, S, Sigma) present and stable
- oOptReady  out  1  scheduler can accept an option; decoded from gen FSM = G_IDLE
- oGenStart  out  1  one-cycle start pulse to both generator banks
- iMuDone  in  1  one-cycle done pulse from ExpMu lane 0
- iSigmaDone  in  1  one-cycle done pulse from ExpSigma lane 0
- oMuBusy  out  1  ExpMu bank running
- oSigmaBusy  out  1  ExpSigma bank running
- oLaneSel  out  SEL_W  round-robin lane index for table write-back mux
- oBank  out  1  table bank written by generators; cores read ~oBank
- oCoreStart  out  1  one-cycle start pulse to all cores
- iCoreDone  in  1  one-cycle done pulse from core 0
- oCoresBusy  out  1  cores running
- oOptCount  out  CNT_W  options completed by cores, wraps modulo 2^CNT_W

## Operation
- Gen FSM states: G_IDLE, G_RUN, G_FULL. Core FSM states: C_IDLE, C_RUN. Internal flags muSeen, sigmaSeen.
- G_IDLE: oOptReady=1. On iOptValid, go to G_RUN and assert oGenStart for one cycle. Set oMuBusy=oSigmaBusy=1 and clear both flags.
- G_RUN: iMuDone sets muSeen and clears oMuBusy. iSigmaDone sets sigmaSeen and clears oSigmaBusy. The two may arrive in the same cycle or in any order. Once both flags are set, including the cycle in which the second done arrives, go to G_FULL.
- G_FULL: tables for the option are complete in bank oBank. Swap when (core FSM = C_IDLE) or iCoreDone=1 in that cycle. Swap means toggle oBank, pulse oCoreStart, go to G_IDLE, and put the core FSM in C_RUN.
- C_RUN: oCoresBusy=1. On iCoreDone, increment oOptCount. Go to C_IDLE unless a swap occurs in the same cycle; with a swap, stay in C_RUN.
- Done pulses received outside G_RUN are ignored. A repeated done pulse for an already-seen flag has no effect.
- oLaneSel: increments modulo GEN_LANES every cycle while oMuBusy or oSigmaBusy is set. It is 0 otherwise and on the cycle either busy clears.
- iCoreDone received in C_IDLE is ignored, and the count is unchanged.

## Timing
- Reset (iRstN=0): G_IDLE, C_IDLE, oBank=0, oLaneSel=0, oOptCount=0, both flags 0. oGenStart, oCoreStart, oMuBusy, oSigmaBusy and oCoresBusy are 0. oOptReady=1, since it is decoded from G_IDLE.
- Reset asserted mid-operation: all of the above take effect immediately, independent of CLK. A pending done or start is lost.
- Accept at edge k: after k, oOptReady=0, oGenStart=1, busies=1. After k+1, oGenStart=0.
- Last done sampled at edge m: after m, state is G_FULL. The earliest swap is edge m+1; after it, oCoreStart=1 and oBank is toggled. After m+2, oCoreStart=0.
- Back-to-back throughput: a new option can be accepted at the edge after a swap. Minimum accept-to-coreStart latency is 3 edges when gen completes in 1 cycle.
- oBank never changes except on a swap edge, so cores always read a stable, complete bank.
- All outputs are registered except oOptReady (state decode).

## Test plan
- Reset then single option: iOptValid at edge 2; iMuDone at edge 10, iSigmaDone at edge 14 -> oGenStart high only after edge 2, oMuBusy low after 10, G_FULL after 14, oCoreStart pulse and oBank 0->1 after 15, oOptReady=1 after 15.
- Simultaneous dones: iMuDone and iSigmaDone both at edge 8 -> both busies clear after 8; swap at edge 9.
- Cores busy when gen finishes: option 2 tables complete while C_RUN -> gen holds G_FULL with oOptReady=0. iCoreDone at edge 40 -> swap at edge 40, oOptCount increments by 1, oCoresBusy stays 1, oBank toggles.
- Lane select: GEN_LANES=3, gen busy for 7 cycles -> oLaneSel sequence 0,1,2,0,1,2,0, then 0 after both done.
- Spurious pulses: iMuDone in G_IDLE and iCoreDone in C_IDLE -> no state, flag or count change.
- Reset mid-run: assert iRstN=0 during G_RUN with C_RUN -> all outputs immediately at reset values. After release, a new option is accepted normally with oBank=0 and oOptCount=0.

Source files
------------

// File: rtl/option_scheduler.sv
// rtl/option_scheduler.sv - generator/core sequencing with double-buffered table bank
// Gen FSM launches and tracks the ExpMu/ExpSigma banks; core FSM overlaps MC simulation with the next table build.
module option_scheduler #(
    parameter int GEN_LANES = 3,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             iRstN,
    input  logic             iOptValid,
    output logic             oOptReady,
    output logic             oGenStart,
    input  logic             iMuDone,
    input  logic             iSigmaDone,
    output logic             oMuBusy,
    output logic             oSigmaBusy,
    output logic [SEL_W-1:0] oLaneSel,
    output logic             oBank,
    output logic             oCoreStart,
    input  logic             iCoreDone,
    output logic             oCoresBusy,
    output logic [CNT_W-1:0] oOptCount
);

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_FULL} gen_state_e;
    typedef enum logic       {C_IDLE, C_RUN} core_state_e;

    gen_state_e       gen_q, gen_d;
    core_state_e      core_q, core_d;
    logic             mu_seen_q, mu_seen_d;
    logic             sigma_seen_q, sigma_seen_d;
    logic             gen_start_q, gen_start_d;
    logic             core_start_q, core_start_d;
    logic             mu_busy_q, mu_busy_d;
    logic             sigma_busy_q, sigma_busy_d;
    logic [SEL_W-1:0] lane_sel_q, lane_sel_d;
    logic             bank_q, bank_d;
    logic [CNT_W-1:0] opt_count_q, opt_count_d;
    logic             swap;
    logic             busy_clear;

    always_comb begin
        gen_d        = gen_q;
        core_d       = core_q;
        mu_seen_d    = mu_seen_q;
        sigma_seen_d = sigma_seen_q;
        gen_start_d  = 1'b0;
        core_start_d = 1'b0;
        mu_busy_d    = mu_busy_q;
        sigma_busy_d = sigma_busy_q;
        bank_d       = bank_q;
        opt_count_d  = opt_count_q;
        lane_sel_d   = lane_sel_q;
        swap         = 1'b0;
        busy_clear   = 1'b0;

        case (gen_q)
            G_IDLE: begin
                if (iOptValid) begin
                    gen_d        = G_RUN;
                    gen_start_d  = 1'b1;
                    mu_busy_d    = 1'b1;
                    sigma_busy_d = 1'b1;
                    mu_seen_d    = 1'b0;
                    sigma_seen_d = 1'b0;
                end
            end
            G_RUN: begin
                if (iMuDone && !mu_seen_q) begin
                    mu_seen_d = 1'b1;
                    mu_busy_d = 1'b0;
                end
                if (iSigmaDone && !sigma_seen_q) begin
                    sigma_seen_d = 1'b1;
                    sigma_busy_d = 1'b0;
                end
                if (mu_seen_d && sigma_seen_d) begin
                    gen_d = G_FULL;
                end
            end
            G_FULL: begin
                // A finishing core frees the read bank in the same cycle, so the swap need not wait for C_IDLE.
                if (core_q == C_IDLE || iCoreDone) begin
                    swap         = 1'b1;
                    bank_d       = ~bank_q;
                    core_start_d = 1'b1;
                    gen_d        = G_IDLE;
                end
            end
            default: gen_d = G_IDLE;
        endcase

        if (core_q == C_RUN && iCoreDone) begin
            opt_count_d = opt_count_q + CNT_W'(1);
            core_d      = C_IDLE;
        end
        if (swap) begin
            core_d = C_RUN;
        end

        busy_clear = (mu_busy_q && !mu_busy_d) || (sigma_busy_q && !sigma_busy_d);
        if (gen_start_d || busy_clear || !(mu_busy_q || sigma_busy_q)) begin
            lane_sel_d = '0;
        end else if (lane_sel_q == SEL_W'(GEN_LANES - 1)) begin
            lane_sel_d = '0;
        end else begin
            lane_sel_d = lane_sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge iRstN) begin
        if (!iRstN) begin
            gen_q        <= G_IDLE;
            core_q       <= C_IDLE;
            mu_seen_q    <= 1'b0;
            sigma_seen_q <= 1'b0;
            gen_start_q  <= 1'b0;
            core_start_q <= 1'b0;
            mu_busy_q    <= 1'b0;
            sigma_busy_q <= 1'b0;
            lane_sel_q   <= '0;
            bank_q       <= 1'b0;
            opt_count_q  <= '0;
        end else begin
            gen_q        <= gen_d;
            core_q       <= core_d;
            mu_seen_q    <= mu_seen_d;
            sigma_seen_q <= sigma_seen_d;
            gen_start_q  <= gen_start_d;
            core_start_q <= core_start_d;
            mu_busy_q    <= mu_busy_d;
            sigma_busy_q <= sigma_busy_d;
            lane_sel_q   <= lane_sel_d;
            bank_q       <= bank_d;
            opt_count_q  <= opt_count_d;
        end
    end

    assign oOptReady  = (gen_q == G_IDLE);
    assign oGenStart  = gen_start_q;
    assign oMuBusy    = mu_busy_q;
    assign oSigmaBusy = sigma_busy_q;
    assign oLaneSel   = lane_sel_q;
    assign oBank      = bank_q;
    assign oCoreStart = core_start_q;
    assign oCoresBusy = (core_q == C_RUN);
    assign oOptCount  = opt_count_q;

endmodule

// File: tb/tb_option_scheduler.sv
// tb/tb_option_scheduler.sv - self-checking bench for option_scheduler
// Behavioural phase model compared every cycle, plus directed literal expectations.
module tb_option_scheduler;

    localparam int GEN_LANES = 3;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 16;

    logic             CLK = 1'b0;
    logic             iRstN;
    logic             iOptValid;
    logic             oOptReady;
    logic             oGenStart;
    logic             iMuDone;
    logic             iSigmaDone;
    logic             oMuBusy;
    logic             oSigmaBusy;
    logic [SEL_W-1:0] oLaneSel;
    logic             oBank;
    logic             oCoreStart;
    logic             iCoreDone;
    logic             oCoresBusy;
    logic [CNT_W-1:0] oOptCount;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    option_scheduler #(.GEN_LANES(GEN_LANES), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .iRstN(iRstN), .iOptValid(iOptValid), .oOptReady(oOptReady),
        .oGenStart(oGenStart), .iMuDone(iMuDone), .iSigmaDone(iSigmaDone),
        .oMuBusy(oMuBusy), .oSigmaBusy(oSigmaBusy), .oLaneSel(oLaneSel),
        .oBank(oBank), .oCoreStart(oCoreStart), .iCoreDone(iCoreDone),
        .oCoresBusy(oCoresBusy), .oOptCount(oOptCount)
    );

    always #5 CLK = ~CLK;

    // Model phases: 0 = waiting for option, 1 = tables building, 2 = tables ready for swap.
    int m_gen   = 0;
    bit m_mu    = 0;
    bit m_sg    = 0;
    int m_sel   = 0;
    bit m_bank  = 0;
    bit m_gst   = 0;
    bit m_cst   = 0;
    bit m_cores = 0;
    int m_cnt   = 0;

    always @(posedge CLK or negedge iRstN) begin : model
        int g_n, sel_n, cnt_n;
        bit mu_n, sg_n, acc, swp, cores_n;
        if (!iRstN) begin
            m_gen <= 0; m_mu <= 0; m_sg <= 0; m_sel <= 0; m_bank <= 0;
            m_gst <= 0; m_cst <= 0; m_cores <= 0; m_cnt <= 0;
        end else begin
            acc  = (m_gen == 0) && iOptValid;
            swp  = (m_gen == 2) && (!m_cores || iCoreDone);
            g_n  = m_gen;
            mu_n = m_mu;
            sg_n = m_sg;
            if (acc) begin
                g_n = 1; mu_n = 1; sg_n = 1;
            end
            if (m_gen == 1) begin
                if (iMuDone) mu_n = 0;
                if (iSigmaDone) sg_n = 0;
                if (!mu_n && !sg_n) g_n = 2;
            end
            if (swp) g_n = 0;
            if (acc || (m_mu && !mu_n) || (m_sg && !sg_n) || !(m_mu || m_sg)) sel_n = 0;
            else sel_n = (m_sel + 1) % GEN_LANES;
            cnt_n   = m_cnt;
            cores_n = m_cores;
            if (m_cores && iCoreDone) begin
                cnt_n   = (m_cnt + 1) % (1 << CNT_W);
                cores_n = 0;
            end
            if (swp) cores_n = 1;
            m_gen   <= g_n;
            m_mu    <= mu_n;
            m_sg    <= sg_n;
            m_sel   <= sel_n;
            m_bank  <= swp ? !m_bank : m_bank;
            m_gst   <= acc;
            m_cst   <= swp;
            m_cores <= cores_n;
            m_cnt   <= cnt_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("ready",     32'(oOptReady),  32'(m_gen == 0));
            chk("genstart",  32'(oGenStart),  32'(m_gst));
            chk("mubusy",    32'(oMuBusy),    32'(m_mu));
            chk("sigmabusy", 32'(oSigmaBusy), 32'(m_sg));
            chk("lanesel",   32'(oLaneSel),   32'(m_sel));
            chk("bank",      32'(oBank),      32'(m_bank));
            chk("corestart", 32'(oCoreStart), 32'(m_cst));
            chk("coresbusy", 32'(oCoresBusy), 32'(m_cores));
            chk("optcount",  32'(oOptCount),  32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},  32'(oOptReady),  32'd1);
        chk({tag, "_gst"},    32'(oGenStart),  32'd0);
        chk({tag, "_cst"},    32'(oCoreStart), 32'd0);
        chk({tag, "_busies"}, 32'({oMuBusy, oSigmaBusy, oCoresBusy}), 32'd0);
        chk({tag, "_sel"},    32'(oLaneSel),   32'd0);
        chk({tag, "_bank"},   32'(oBank),      32'd0);
        chk({tag, "_cnt"},    32'(oOptCount),  32'd0);
    endtask

    initial begin
        iRstN = 1'b1; iOptValid = 1'b0; iMuDone = 1'b0; iSigmaDone = 1'b0; iCoreDone = 1'b0;
        #1 iRstN = 1'b0;
        #2 check_reset_values("por");
        @(posedge CLK); @(posedge CLK); #1;
        iRstN  = 1'b1;
        cmp_en = 1'b1;
        step();

        // Single option, staggered dones, cores idle
        iOptValid = 1'b1; step(); iOptValid = 1'b0;
        chk("acc_gst", 32'(oGenStart), 32'd1);
        chk("acc_rdy", 32'(oOptReady), 32'd0);
        chk("acc_busy", 32'({oMuBusy, oSigmaBusy}), 32'd3);
        step();
        chk("acc_gst_drop", 32'(oGenStart), 32'd0);
        steps(5);
        iMuDone = 1'b1; step(); iMuDone = 1'b0;
        chk("mu_clear", 32'({oMuBusy, oSigmaBusy}), 32'd1);
        steps(3);
        iSigmaDone = 1'b1; step(); iSigmaDone = 1'b0;
        chk("full_rdy", 32'(oOptReady), 32'd0);
        chk("full_busy", 32'({oMuBusy, oSigmaBusy}), 32'd0);
        step();
        chk("swap1_cst", 32'(oCoreStart), 32'd1);
        chk("swap1_bank", 32'(oBank), 32'd1);
        chk("swap1_rdy", 32'(oOptReady), 32'd1);
        step();
        chk("swap1_cst_drop", 32'(oCoreStart), 32'd0);

        // Option 2 with simultaneous dones while cores still run: hold in full state
        iOptValid = 1'b1; step(); iOptValid = 1'b0;
        iMuDone = 1'b1; iSigmaDone = 1'b1; step(); iMuDone = 1'b0; iSigmaDone = 1'b0;
        chk("sim_busy", 32'({oMuBusy, oSigmaBusy}), 32'd0);
        steps(4);
        chk("hold_rdy", 32'(oOptReady), 32'd0);
        chk("hold_bank", 32'(oBank), 32'd1);
        iCoreDone = 1'b1; step(); iCoreDone = 1'b0;
        chk("swap2_cst", 32'(oCoreStart), 32'd1);
        chk("swap2_bank", 32'(oBank), 32'd0);
        chk("swap2_cnt", 32'(oOptCount), 32'd1);
        chk("swap2_cores", 32'(oCoresBusy), 32'd1);

        // Option 3: lane select over 7 busy cycles
        iOptValid = 1'b1; step(); iOptValid = 1'b0;
        chk("lane0", 32'(oLaneSel), 32'd0);
        for (int i = 1; i < 7; i++) begin
            step();
            chk("lane_seq", 32'(oLaneSel), 32'(i % 3));
        end
        iMuDone = 1'b1; iSigmaDone = 1'b1; step(); iMuDone = 1'b0; iSigmaDone = 1'b0;
        chk("lane_done", 32'(oLaneSel), 32'd0);
        iCoreDone = 1'b1; step(); iCoreDone = 1'b0;
        chk("swap3_cnt", 32'(oOptCount), 32'd2);
        chk("swap3_bank", 32'(oBank), 32'd1);
        iCoreDone = 1'b1; step(); iCoreDone = 1'b0;
        chk("cores_done", 32'({oCoresBusy, oOptCount}), 32'h3);

        // Spurious pulses in idle states
        iCoreDone = 1'b1; step(); iCoreDone = 1'b0;
        chk("spur_core_cnt", 32'(oOptCount), 32'd3);
        iMuDone = 1'b1; step(); iMuDone = 1'b0;
        chk("spur_mu", 32'({oOptReady, oMuBusy}), 32'h2);
        iOptValid = 1'b1; step(); iOptValid = 1'b0;
        iSigmaDone = 1'b1; step(); iSigmaDone = 1'b0;
        chk("spur_flag", 32'({oOptReady, oMuBusy}), 32'h1);
        iSigmaDone = 1'b1; step(); iSigmaDone = 1'b0;
        chk("rep_sigma", 32'({oOptReady, oMuBusy}), 32'h1);
        iMuDone = 1'b1; step(); iMuDone = 1'b0;
        step();
        chk("swap4_cst", 32'(oCoreStart), 32'd1);
        chk("swap4_bank", 32'(oBank), 32'd0);

        // Reset mid-run with cores running and gen building
        iOptValid = 1'b1; step(); iOptValid = 1'b0;
        steps(2);
        iRstN = 1'b0;
        #2 check_reset_values("midrst");
        step();
        iRstN = 1'b1;
        step();
        iOptValid = 1'b1; step(); iOptValid = 1'b0;
        chk("post_gst", 32'(oGenStart), 32'd1);
        chk("post_bank", 32'(oBank), 32'd0);
        chk("post_cnt", 32'(oOptCount), 32'd0);
        iMuDone = 1'b1; iSigmaDone = 1'b1; step(); iMuDone = 1'b0; iSigmaDone = 1'b0;
        step();
        chk("post_swap", 32'({oCoreStart, oBank}), 32'h3);
        steps(3);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
